// File: rtl/axi_vdma_pkg.sv
// axi_vdma_pkg: shared state encoding and AXI beat/boundary constants
package axi_vdma_pkg;
  typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT_DONE, FIN, ERR} state_t;
  localparam int BEAT_BYTES_LOG2 = 5;
  localparam int BOUNDARY_BYTES = 4096;
endpackage

// File: rtl/axi_burst_len_calc.sv
// axi_burst_len_calc: burst length limited by remaining beats, MAX_BURST and the next 4 KB boundary
module axi_burst_len_calc
  import axi_vdma_pkg::*;
#(
  parameter int LSIZE = 10,
  parameter int TSIZE = 24,
  parameter int MAX_BURST = 128
) (
  input  logic [11:0]      cur_addr,
  input  logic [TSIZE-1:0] remaining,
  output logic [LSIZE-1:0] blen
);
  logic [12:0] span;
  logic [31:0] to_4k;
  logic [31:0] lim;
  // beats left before the 4 KB page ends, then clamp to the burst and transfer limits
  always_comb begin
    span = 13'(BOUNDARY_BYTES) - {1'b0, cur_addr};
    to_4k = 32'(span >> BEAT_BYTES_LOG2);
    lim = (to_4k < 32'(MAX_BURST)) ? to_4k : 32'(MAX_BURST);
    blen = (32'(remaining) < lim) ? LSIZE'(remaining) : LSIZE'(lim);
  end
endmodule

// File: rtl/axi_wr_burst_splitter.sv
// axi_wr_burst_splitter: splits a linear write transfer into 4 KB-safe INCR bursts for the write core
module axi_wr_burst_splitter
  import axi_vdma_pkg::*;
#(
  parameter int LSIZE = 10,
  parameter int ASIZE = 32,
  parameter int TSIZE = 24,
  parameter int MAX_BURST = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             start,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [TSIZE-1:0] total_beats,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             write_req,
  output logic [LSIZE-1:0] req_len,
  output logic [ASIZE-1:0] req_addr,
  input  logic             req_resp,
  input  logic             req_done
);
  state_t state_q, state_d;
  logic [ASIZE-1:0] addr_q, addr_d, req_addr_q, req_addr_d;
  logic [TSIZE-1:0] rem_q, rem_d, nxt_rem;
  logic [LSIZE-1:0] req_len_q, req_len_d, blen;
  logic [31:0] tcnt_q, tcnt_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, write_req_q, write_req_d;
  logic timeout;

  axi_burst_len_calc #(.LSIZE(LSIZE), .TSIZE(TSIZE), .MAX_BURST(MAX_BURST)) u_calc (
    .cur_addr (addr_q[11:0]),
    .remaining(rem_q),
    .blen     (blen)
  );

  // next state, datapath updates and outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    req_len_d = req_len_q;
    req_addr_d = req_addr_q;
    tcnt_d = tcnt_q;
    nxt_rem = rem_q - TSIZE'(req_len_q);
    timeout = (TIMEOUT != 0) && (tcnt_q == 32'(TIMEOUT - 1));
    case (state_q)
      IDLE: if (start) begin
        addr_d = {base_addr[ASIZE-1:BEAT_BYTES_LOG2], {BEAT_BYTES_LOG2{1'b0}}};
        rem_d = total_beats;
        state_d = (total_beats == '0) ? FIN : CALC;
      end
      CALC: begin
        req_len_d = blen;
        req_addr_d = addr_q;
        tcnt_d = '0;
        state_d = REQ;
      end
      REQ: begin
        tcnt_d = tcnt_q + 32'd1;
        state_d = timeout ? ERR : req_resp ? WAIT_DONE : REQ;
      end
      WAIT_DONE: begin
        tcnt_d = tcnt_q + 32'd1;
        if (req_done) begin
          rem_d = nxt_rem;
          addr_d = addr_q + (ASIZE'(req_len_q) << BEAT_BYTES_LOG2);
          state_d = (nxt_rem == '0) ? FIN : CALC;
        end else if (timeout) state_d = ERR;
      end
      FIN: state_d = done_q ? IDLE : FIN;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && !(state_d == FIN && state_q == FIN);
    done_d = (state_d == FIN) && (state_q != IDLE);
    err_d = (state_d == ERR);
    write_req_d = (state_d == REQ);
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      req_len_q <= '0;
      req_addr_q <= '0;
      tcnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      write_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      req_len_q <= req_len_d;
      req_addr_q <= req_addr_d;
      tcnt_q <= tcnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      write_req_q <= write_req_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign write_req = write_req_q;
  assign req_len = req_len_q;
  assign req_addr = req_addr_q;
endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// tb_axi_wr_burst_splitter: directed and randomized transfers checked against an arithmetic burst model
module tb_axi_wr_burst_splitter;
  localparam int MB = 128;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] total_beats = '0;
  logic busy, done, err, write_req, req_resp, req_done;
  logic [9:0] req_len;
  logic [31:0] req_addr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_wr_burst_splitter #(.LSIZE(10), .ASIZE(32), .TSIZE(24), .MAX_BURST(MB), .TIMEOUT(16)) dut (
    .axi_aclk   (clk),
    .axi_resetn (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .total_beats(total_beats),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .write_req  (write_req),
    .req_len    (req_len),
    .req_addr   (req_addr),
    .req_resp   (req_resp),
    .req_done   (req_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input bit noise);
    if (noise) begin
      start = 1'($urandom_range(0, 1));
      base_addr = $urandom;
      total_beats = 24'($urandom_range(1, 999));
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input int total, input bit noise);
    logic [31:0] ea[$];
    int el[$];
    logic [31:0] a;
    int r, b, t4;
    a = base & 32'hFFFF_FFE0;
    r = total;
    while (r > 0) begin
      t4 = (4096 - int'(a[11:0])) / 32;
      b = (r < MB) ? r : MB;
      b = (b < t4) ? b : t4;
      el.push_back(b);
      ea.push_back(a);
      a = a + 32'(b * 32);
      r -= b;
    end
    start = 1'b1;
    base_addr = base;
    total_beats = 24'(total);
    tick;
    start = 1'b0;
    chk("busy_c1", busy, 1);
    chk("wreq_c1", write_req, 0);
    if (total == 0) begin
      chk("done_c1", done, 0);
      tick;
      chk("done_c2", done, 1);
      chk("busy_c2", busy, 0);
      chk("wreq_c2", write_req, 0);
      tick;
      chk("done_c3", done, 0);
      return;
    end
    tick;
    for (int i = 0; i < el.size(); i++) begin
      chk("wreq_up", write_req, 1);
      chk("req_len", req_len, el[i]);
      chk("req_addr", req_addr, ea[i]);
      repeat ($urandom_range(0, 3)) begin
        poke(noise);
        tick;
        chk("wreq_hold", write_req, 1);
        chk("len_hold", req_len, el[i]);
      end
      start = 1'b0;
      req_resp = 1'b1;
      tick;
      req_resp = 1'b0;
      chk("wreq_drop", write_req, 0);
      repeat ($urandom_range(0, 4)) begin
        poke(noise);
        tick;
        chk("done_early", done, 0);
        chk("addr_hold", req_addr, ea[i]);
      end
      start = 1'b0;
      req_done = 1'b1;
      tick;
      req_done = 1'b0;
      if (i == el.size() - 1) begin
        chk("done_pulse", done, 1);
        chk("busy_fin", busy, 1);
        tick;
        chk("done_clr", done, 0);
        chk("busy_clr", busy, 0);
        chk("err_none", err, 0);
      end else begin
        chk("wreq_calc", write_req, 0);
        chk("busy_calc", busy, 1);
        tick;
      end
    end
  endtask

  initial begin
    req_resp = 1'b0;
    req_done = 1'b0;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wreq", write_req, 0);
    chk("rst_len", req_len, 0);
    chk("rst_addr", req_addr, 0);
    rstn = 1'b1;
    tick;
    run_xfer(32'h0000_0000, 300, 1'b0);
    run_xfer(32'h0000_0F80, 10, 1'b0);
    run_xfer(32'h0000_0F9F, 10, 1'b1);
    run_xfer(32'h0000_0000, 0, 1'b0);
    run_xfer(32'hFFFF_F000, 200, 1'b0);
    start = 1'b1;
    base_addr = 32'h40;
    total_beats = 24'd4;
    tick;
    start = 1'b0;
    tick;
    chk("to_wreq", write_req, 1);
    req_resp = 1'b1;
    tick;
    req_resp = 1'b0;
    repeat (14) tick;
    chk("to_err_early", err, 0);
    tick;
    chk("to_err", err, 1);
    chk("to_done", done, 0);
    tick;
    chk("to_err_clr", err, 0);
    chk("to_busy", busy, 0);
    chk("to_wreq_clr", write_req, 0);
    start = 1'b1;
    base_addr = 32'h200;
    total_beats = 24'd20;
    tick;
    start = 1'b0;
    tick;
    req_resp = 1'b1;
    tick;
    req_resp = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    chk("ar_wreq", write_req, 0);
    chk("ar_len", req_len, 0);
    chk("ar_addr", req_addr, 0);
    tick;
    rstn = 1'b1;
    tick;
    run_xfer(32'h0000_0100, 8, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] bs;
      bs = $urandom;
      if (k[0]) bs[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
      run_xfer(bs, $urandom_range(1, 400), 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_wr_burst_splitter.md
# axi_wr_burst_splitter

Upstream command stage for the AXI write state core. It takes one linear write transfer (base address plus total beat count) and splits it into AXI INCR bursts. Each burst is no longer than `MAX_BURST` beats and never crosses a 4 KB boundary. Bursts are issued one at a time over the core's `write_req` / `req_resp` / `req_done` handshake, and the block reports transfer completion or a timeout.

## Interface
- `LSIZE`, 10: width of `req_len`. `MAX_BURST` must be < 2^LSIZE.
- `ASIZE`, 32: address width.
- `TSIZE`, 24: width of `total_beats`.
- `MAX_BURST`, 128: maximum beats per burst. Range 1..128.
- `TIMEOUT`, 4096: cycle limit from `write_req` assertion to `req_done`. A value of 0 disables the timeout.

Ports (clock and reset first):
- `axi_aclk`  in  1: clock.
- `axi_resetn`  in  1: reset. One clock; reset is asynchronous and active-low.
- `start`  in  1: one-cycle pulse that launches a transfer. Ignored while `busy`=1.
- `base_addr`  in  ASIZE: byte address, sampled on `start`. Bits [4:0] are forced to 0.
- `total_beats`  in  TSIZE: beats of 32 bytes each, sampled on `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done` or `err`.
- `done`  out  1: one-cycle pulse when all bursts have completed.
- `err`  out  1: one-cycle pulse when a timeout aborts the transfer.
- `write_req`  out  1: burst request to the core.
- `req_len`  out  LSIZE: beats in the current burst, 1..MAX_BURST.
- `req_addr`  out  ASIZE: start byte address of the current burst.
- `req_resp`  in  1: core has accepted the request (AW phase in progress).
- `req_done`  in  1: core reports burst complete with an OKAY response.

## Operation
- States: IDLE, CALC, REQ, WAIT_DONE, FIN, ERR.
- IDLE:
  - On `start`, latch `cur_addr` = {base_addr[ASIZE-1:5], 5'b0} and `remaining` = `total_beats`.
  - Go to FIN if `total_beats`==0, otherwise to CALC.
- CALC:
  - Compute `to_4k` = (4096 − cur_addr[11:0]) >> 5, range 1..128.
  - Compute `blen` = min(remaining, MAX_BURST, to_4k).
  - Register `req_len`=blen and `req_addr`=cur_addr. Go to REQ.
- REQ:
  - `write_req`=1 and is held until `req_resp`=1 is sampled, then go to WAIT_DONE.
  - `req_len` and `req_addr` stay stable throughout REQ and WAIT_DONE.
- WAIT_DONE:
  - On `req_done`: `remaining` −= req_len and `cur_addr` += req_len<<5, with the address wrapping modulo 2^ASIZE.
  - Next state is FIN if the new `remaining`==0, otherwise CALC.
- FIN: pulse `done`, return to IDLE.
- ERR: pulse `err`, return to IDLE. The remaining beats are discarded.
- Timeout:
  - A counter is cleared on entry to REQ and counts in REQ and WAIT_DONE.
  - When it reaches TIMEOUT with no `req_done`, go to ERR. This covers the core's silent BERR path.
- `req_resp` or `req_done` arriving outside REQ / WAIT_DONE is ignored.
- `start` while busy is ignored and does not alter the latched values.

## Timing
- All outputs are registered and decoded from the next state.
- Reset values: `busy`, `done`, `err`, `write_req` = 0; `req_len`, `req_addr` = 0; state = IDLE.
- `start` at cycle 0:
  - `busy`=1 at cycle 1.
  - `req_len` / `req_addr` valid at cycle 2.
  - `write_req`=1 at cycle 2.
- `req_resp` sampled at cycle n → `write_req`=0 at cycle n+1.
- `req_done` at cycle m:
  - Next `write_req` at m+2 (through CALC).
  - Alternatively `done`=1 at m+1, with `busy`=0 at m+2.
- `total_beats`=0: `done`=1 at cycle 2 and no `write_req` is issued. `busy` is high only at cycle 1.
- Reset asserted in any state forces all outputs to their reset values immediately (asynchronously).
- The `req_len` subtraction never underflows, because blen ≤ remaining by construction.

## Structure
Shared package `axi_vdma_pkg` holds:
- State encoding.
- `BEAT_BYTES_LOG2`=5, matching AxSIZE 3'b101.
- `BOUNDARY_BYTES`=4096.

One combinational sub-module, `axi_burst_len_calc`:
- Inputs: `cur_addr[11:0]`, `remaining`, `MAX_BURST`.
- Output: `blen`.
- Instantiated once, in CALC.

The top level contains the FSM, the address and remaining registers, and the timeout counter.

## Test plan
- base 0x0000, total 300, MAX_BURST 128 → bursts (128, 0x0000), (128, 0x1000), (44, 0x2000), then `done`.
- base 0x0F80, total 10 → (4, 0x0F80), then (6, 0x1000) with no 4 KB crossing. base 0x0F9F gives the same result because the low bits are masked.
- total 0 → `done` at cycle 2, `write_req` never asserted.
- TIMEOUT=16, `req_resp` given, `req_done` withheld → `err` pulse 16 cycles after `write_req` rises, `busy` low, no `done`.
- `axi_resetn` low during WAIT_DONE → all outputs 0 with no clock edge. After release a new `start` (base 0x100, total 8) yields (8, 0x100).
- Second `start` with different values during a transfer → ignored, and the original burst sequence completes unchanged.
